// File: rtl/accel_mem_pkg.sv
// Shared definitions for the accelerator memory bridge: default widths,
// FSM state encodings and the value driven on the 64-bit ready strobes.
package accel_mem_pkg;

   localparam int DEF_ADDR_W = 64;
   localparam int DEF_DATA_W = 32;

   // Ready strobes are 64 bits wide on the wrapper side but only ever carry 1
   localparam logic [63:0] READY_PULSE = 64'd1;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_REQ  = 3'd1;
   localparam logic [2:0] S_RD_WAIT = 3'd2;
   localparam logic [2:0] S_RD_HOLD = 3'd3;
   localparam logic [2:0] S_WR_REQ  = 3'd4;
   localparam logic [2:0] S_WR_WAIT = 3'd5;
   localparam logic [2:0] S_WR_HOLD = 3'd6;

   // Memory requests carry an 8-bit byte count; the wrapper supplies 64 bits
   function automatic logic [7:0] req_size_of(input logic [7:0] size_lo);
      return size_lo;
   endfunction

endpackage

// File: rtl/accel_mem_bridge_if.sv
// Valid/ready memory request bus with a simple response strobe.
// master = bridge (issues requests), slave = memory.
interface accel_mem_bridge_if
   import accel_mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              mem_req_valid;
   logic              mem_req_ready;
   logic              mem_req_write;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [7:0]        mem_req_size;
   logic [DATA_W-1:0] mem_req_wdata;
   logic              mem_resp_valid;
   logic [DATA_W-1:0] mem_resp_rdata;

   modport master (
      output mem_req_valid, mem_req_write, mem_req_addr, mem_req_size, mem_req_wdata,
      input  mem_req_ready, mem_resp_valid, mem_resp_rdata
   );

   modport slave (
      input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_size, mem_req_wdata,
      output mem_req_ready, mem_resp_valid, mem_resp_rdata
   );
endinterface

// File: rtl/accel_mem_timer.sv
// Response watchdog: counts enabled cycles and flags the cycle in which the
// TIMEOUT-th enabled cycle is reached. Clear has priority over counting.
module accel_mem_timer #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] count;

   // Cycle counter, frozen once the terminal count is reached
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && !tc)
         count <= count + CW'(1);
   end

   assign tc = enable && (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/accel_mem_bridge.sv
// Memory-side stage of the accelerator wrapper. Converts the wrapper's
// word-level read/write handshakes into single-outstanding valid/ready memory
// requests and returns one-cycle ready strobes per completed word.
module accel_mem_bridge
   import accel_mem_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = 4096
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               read_enable,
   input  logic [ADDR_W-1:0]  read_addr,
   input  logic [63:0]        read_size,
   input  logic               finish_read,
   output logic [63:0]        read_ready,
   output logic [DATA_W-1:0]  read_data,
   input  logic               write_enable,
   input  logic [ADDR_W-1:0]  write_addr,
   input  logic [63:0]        write_size,
   input  logic [DATA_W-1:0]  write_data,
   input  logic               finish_write,
   output logic [63:0]        write_ready,
   accel_mem_bridge_if.master mem,
   output logic [31:0]        rd_words,
   output logic [31:0]        wr_words,
   output logic               err
);
   logic [2:0]        state;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [7:0]        req_size;
   logic [DATA_W-1:0] req_wdata;
   logic              rd_pulse;
   logic              wr_pulse;
   logic              drop;
   logic              tmr_clear;
   logic              tmr_en;
   logic              tmr_tc;

   // Only the low byte of the wrapper size fields is forwarded
   logic size_unused;
   assign size_unused = ^{read_size[63:8], write_size[63:8]};

   assign tmr_clear = (state == S_RD_REQ) || (state == S_WR_REQ);
   assign tmr_en    = (state == S_RD_WAIT) || (state == S_WR_WAIT);

   accel_mem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (tmr_clear),
      .enable (tmr_en),
      .tc     (tmr_tc)
   );

   assign mem.mem_req_valid = (state == S_RD_REQ) || (state == S_WR_REQ);
   assign mem.mem_req_write = req_write;
   assign mem.mem_req_addr  = req_addr;
   assign mem.mem_req_size  = req_size;
   assign mem.mem_req_wdata = req_wdata;

   assign read_ready  = rd_pulse ? READY_PULSE : '0;
   assign write_ready = wr_pulse ? READY_PULSE : '0;

   // Transaction FSM with request holding registers, response capture and counters.
   // 'drop' marks an accepted request whose stream was withdrawn: its response is
   // consumed silently.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         req_write <= 1'b0;
         req_addr  <= '0;
         req_size  <= '0;
         req_wdata <= '0;
         read_data <= '0;
         rd_pulse  <= 1'b0;
         wr_pulse  <= 1'b0;
         drop      <= 1'b0;
         rd_words  <= '0;
         wr_words  <= '0;
         err       <= 1'b0;
      end else begin
         rd_pulse <= 1'b0;
         wr_pulse <= 1'b0;
         case (state)
            S_IDLE: begin
               drop <= 1'b0;
               if (read_enable) begin
                  state     <= S_RD_REQ;
                  req_write <= 1'b0;
                  req_addr  <= read_addr;
                  req_size  <= req_size_of(read_size[7:0]);
               end else if (write_enable) begin
                  state     <= S_WR_REQ;
                  req_write <= 1'b1;
                  req_addr  <= write_addr;
                  req_size  <= req_size_of(write_size[7:0]);
                  req_wdata <= write_data;
               end
            end
            S_RD_REQ: begin
               if (mem.mem_req_ready) begin
                  state <= S_RD_WAIT;
                  drop  <= !read_enable;
               end else if (!read_enable) begin
                  state <= S_IDLE;
               end
            end
            S_RD_WAIT: begin
               if (!read_enable)
                  drop <= 1'b1;
               if (mem.mem_resp_valid) begin
                  if (drop || !read_enable) begin
                     state <= S_IDLE;
                  end else begin
                     read_data <= mem.mem_resp_rdata;
                     rd_pulse  <= 1'b1;
                     rd_words  <= rd_words + 32'd1;
                     state     <= S_RD_HOLD;
                  end
               end else if (tmr_tc) begin
                  err   <= 1'b1;
                  state <= S_IDLE;
               end
            end
            S_RD_HOLD: begin
               if (!read_enable) begin
                  state <= S_IDLE;
               end else if (finish_read) begin
                  state    <= S_RD_REQ;
                  req_addr <= read_addr;
                  req_size <= req_size_of(read_size[7:0]);
               end
            end
            S_WR_REQ: begin
               if (mem.mem_req_ready) begin
                  state <= S_WR_WAIT;
                  drop  <= !write_enable;
               end else if (!write_enable) begin
                  state <= S_IDLE;
               end
            end
            S_WR_WAIT: begin
               if (!write_enable)
                  drop <= 1'b1;
               if (mem.mem_resp_valid) begin
                  if (drop || !write_enable) begin
                     state <= S_IDLE;
                  end else begin
                     wr_pulse <= 1'b1;
                     wr_words <= wr_words + 32'd1;
                     state    <= S_WR_HOLD;
                  end
               end else if (tmr_tc) begin
                  err   <= 1'b1;
                  state <= S_IDLE;
               end
            end
            S_WR_HOLD: begin
               if (!write_enable) begin
                  state <= S_IDLE;
               end else if (finish_write) begin
                  state     <= S_WR_REQ;
                  req_addr  <= write_addr;
                  req_size  <= req_size_of(write_size[7:0]);
                  req_wdata <= write_data;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_accel_mem_bridge.sv
// Directed bench for accel_mem_bridge: a small latency-programmable memory
// responder, a bus/strobe logger, and a linear sequence of directed steps.
module tb_accel_mem_bridge;
   import accel_mem_pkg::*;

   localparam int AW = 64;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          read_enable = 1'b0;
   logic [AW-1:0] read_addr = '0;
   logic [63:0]   read_size = '0;
   logic          finish_read = 1'b0;
   logic [63:0]   read_ready;
   logic [DW-1:0] read_data;
   logic          write_enable = 1'b0;
   logic [AW-1:0] write_addr = '0;
   logic [63:0]   write_size = '0;
   logic [DW-1:0] write_data = '0;
   logic          finish_write = 1'b0;
   logic [63:0]   write_ready;
   logic [31:0]   rd_words;
   logic [31:0]   wr_words;
   logic          err;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   accel_mem_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

   accel_mem_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .read_enable  (read_enable),
      .read_addr    (read_addr),
      .read_size    (read_size),
      .finish_read  (finish_read),
      .read_ready   (read_ready),
      .read_data    (read_data),
      .write_enable (write_enable),
      .write_addr   (write_addr),
      .write_size   (write_size),
      .write_data   (write_data),
      .finish_write (finish_write),
      .write_ready  (write_ready),
      .mem          (mif),
      .rd_words     (rd_words),
      .wr_words     (wr_words),
      .err          (err)
   );

   // Logger: requests accepted, strobes seen, strobe-shape violations
   logic [AW-1:0] req_addr_q[$];
   logic          req_wr_q[$];
   logic [DW-1:0] req_wd_q[$];
   logic [7:0]    req_sz_q[$];
   logic [DW-1:0] rdp_q[$];
   int            n_wrp = 0;
   int            pulse_bad = 0;
   int            lat_bad = 0;
   logic          hs_seen = 1'b0;
   logic [AW-1:0] hs_addr = '0;
   logic          prev_rd = 1'b0;
   logic          prev_wr = 1'b0;
   logic          prev_resp = 1'b0;

   always @(negedge clk) begin
      hs_seen = mif.mem_req_valid && mif.mem_req_ready;
      hs_addr = mif.mem_req_addr;
      if (hs_seen) begin
         req_addr_q.push_back(mif.mem_req_addr);
         req_wr_q.push_back(mif.mem_req_write);
         req_wd_q.push_back(mif.mem_req_wdata);
         req_sz_q.push_back(mif.mem_req_size);
      end
      if (read_ready != 64'd0) begin
         if (read_ready !== 64'd1 || prev_rd || prev_wr || write_ready != 64'd0) pulse_bad++;
         if (!prev_resp) lat_bad++;
         rdp_q.push_back(read_data);
      end
      if (write_ready != 64'd0) begin
         if (write_ready !== 64'd1 || prev_wr || prev_rd) pulse_bad++;
         if (!prev_resp) lat_bad++;
         n_wrp++;
      end
      prev_rd   = (read_ready != 64'd0);
      prev_wr   = (write_ready != 64'd0);
      prev_resp = mif.mem_resp_valid;
   end

   // Memory responder: answers each accepted request after mem_lat cycles
   int            mem_lat = 3;
   bit            resp_en = 1'b1;
   bit            pend = 1'b0;
   int            pend_cnt = 0;
   logic [DW-1:0] pend_data = '0;

   initial begin
      mif.mem_resp_valid = 1'b0;
      mif.mem_resp_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         mif.mem_resp_valid = 1'b0;
         if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               pend = 1'b0;
               if (resp_en) begin
                  mif.mem_resp_valid = 1'b1;
                  mif.mem_resp_rdata = pend_data;
               end
            end
         end
         if (hs_seen) begin
            pend      = 1'b1;
            pend_cnt  = mem_lat;
            pend_data = hs_addr[31:0] ^ 32'hA5A5_0000;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_rd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (read_ready == 64'd1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_wr(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (write_ready == 64'd1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic read_stream(input logic [AW-1:0] base, input int n);
      bit ok;
      read_addr   = base;
      read_size   = 64'd4;
      read_enable = 1'b1;
      for (int w = 0; w < n; w++) begin
         wait_rd(ok);
         chk("rd_pulse_seen", 64'(ok), 64'd1);
         tick();
         if (w < n - 1) begin
            read_addr   = read_addr + 64'd4;
            finish_read = 1'b1;
            tick();
            finish_read = 1'b0;
         end else begin
            read_enable = 1'b0;
         end
      end
      tick();
   endtask

   task automatic write_stream(input logic [AW-1:0] base, input int n);
      bit ok;
      write_addr   = base;
      write_size   = 64'd4;
      write_data   = 32'd1;
      write_enable = 1'b1;
      for (int w = 0; w < n; w++) begin
         wait_wr(ok);
         chk("wr_pulse_seen", 64'(ok), 64'd1);
         tick();
         if (w < n - 1) begin
            write_addr   = write_addr + 64'd4;
            write_data   = write_data + 32'd1;
            finish_write = 1'b1;
            tick();
            finish_write = 1'b0;
         end else begin
            write_enable = 1'b0;
         end
      end
      tick();
   endtask

   int r0;
   int p0;
   int tcyc;
   bit ok;

   initial begin
      mif.mem_req_ready = 1'b1;

      // Reset state
      tick(); tick();
      chk("rst_req_valid", 64'(mif.mem_req_valid), 64'd0);
      chk("rst_read_ready", read_ready, 64'd0);
      chk("rst_write_ready", write_ready, 64'd0);
      chk("rst_rd_words", 64'(rd_words), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_read_data", 64'(read_data), 64'd0);
      reset = 1'b0;
      tick();

      // 4-word read at 0x1000, memory latency 3
      mem_lat = 3;
      r0 = req_addr_q.size();
      read_stream(64'h1000, 4);
      chk("rd4_req_count", 64'(req_addr_q.size() - r0), 64'd4);
      chk("rd4_addr0", req_addr_q[r0], 64'h1000);
      chk("rd4_addr1", req_addr_q[r0+1], 64'h1004);
      chk("rd4_addr3", req_addr_q[r0+3], 64'h100C);
      chk("rd4_is_read", 64'(req_wr_q[r0]), 64'd0);
      chk("rd4_size", 64'(req_sz_q[r0]), 64'd4);
      chk("rd4_pulses", 64'(rdp_q.size()), 64'd4);
      chk("rd4_data0", 64'(rdp_q[0]), 64'hA5A51000);
      chk("rd4_data3", 64'(rdp_q[3]), 64'hA5A5100C);
      chk("rd4_rd_words", 64'(rd_words), 64'd4);

      // 3-word write at 0x2000, data 1,2,3
      r0 = req_addr_q.size();
      write_stream(64'h2000, 3);
      chk("wr3_addr0", req_addr_q[r0], 64'h2000);
      chk("wr3_addr2", req_addr_q[r0+2], 64'h2008);
      chk("wr3_is_write", 64'(req_wr_q[r0+1]), 64'd1);
      chk("wr3_data0", 64'(req_wd_q[r0]), 64'd1);
      chk("wr3_data1", 64'(req_wd_q[r0+1]), 64'd2);
      chk("wr3_data2", 64'(req_wd_q[r0+2]), 64'd3);
      chk("wr3_pulses", 64'(n_wrp), 64'd3);
      chk("wr3_wr_words", 64'(wr_words), 64'd3);

      // Read and write enabled in the same cycle: read first
      r0 = req_addr_q.size();
      read_addr = 64'h3000;  read_size = 64'd4;
      write_addr = 64'h4000; write_size = 64'd4; write_data = 32'hBEEF;
      read_enable = 1'b1;
      write_enable = 1'b1;
      wait_rd(ok);
      chk("both_rd_pulse", 64'(ok), 64'd1);
      tick();
      read_enable = 1'b0;
      wait_wr(ok);
      chk("both_wr_pulse", 64'(ok), 64'd1);
      tick();
      write_enable = 1'b0;
      tick();
      chk("both_first_read", 64'(req_wr_q[r0]), 64'd0);
      chk("both_first_addr", req_addr_q[r0], 64'h3000);
      chk("both_second_write", 64'(req_wr_q[r0+1]), 64'd1);
      chk("both_second_addr", req_addr_q[r0+1], 64'h4000);
      chk("both_wdata", 64'(req_wd_q[r0+1]), 64'hBEEF);
      chk("both_rd_words", 64'(rd_words), 64'd5);
      chk("both_wr_words", 64'(wr_words), 64'd4);

      // mem_req_ready held low 10 cycles: request and fields stable
      mif.mem_req_ready = 1'b0;
      r0 = req_addr_q.size();
      read_addr = 64'h5000;
      read_enable = 1'b1;
      tick();
      read_addr = 64'h5555;
      for (int i = 0; i < 10; i++) begin
         chk("hold_valid", 64'(mif.mem_req_valid), 64'd1);
         chk("hold_addr", mif.mem_req_addr, 64'h5000);
         chk("hold_write", 64'(mif.mem_req_write), 64'd0);
         chk("hold_size", 64'(mif.mem_req_size), 64'd4);
         tick();
      end
      chk("hold_no_accept", 64'(req_addr_q.size() - r0), 64'd0);
      mif.mem_req_ready = 1'b1;
      wait_rd(ok);
      chk("hold_rd_pulse", 64'(ok), 64'd1);
      chk("hold_read_data", 64'(read_data), 64'hA5A55000);
      read_enable = 1'b0;
      tick(); tick();
      chk("hold_no_err", 64'(err), 64'd0);

      // No response: err after 16 cycles in RD_WAIT, no strobe
      resp_en = 1'b0;
      p0 = rdp_q.size();
      read_addr = 64'h6000;
      read_enable = 1'b1;
      tcyc = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (err === 1'b1) begin
            tcyc = i;
            break;
         end
      end
      read_enable = 1'b0;
      chk("to_cycles", 64'(tcyc), 64'd18);
      tick();
      chk("to_err", 64'(err), 64'd1);
      chk("to_idle", 64'(mif.mem_req_valid), 64'd0);
      chk("to_no_pulse", 64'(rdp_q.size() - p0), 64'd0);
      chk("to_rd_words", 64'(rd_words), 64'd6);
      tick(); tick(); tick(); tick();
      resp_en = 1'b1;

      // read_enable dropped before accept: request withdrawn
      mif.mem_req_ready = 1'b0;
      r0 = req_addr_q.size();
      read_addr = 64'h8000;
      read_enable = 1'b1;
      tick(); tick();
      chk("wd_valid_up", 64'(mif.mem_req_valid), 64'd1);
      read_enable = 1'b0;
      tick();
      chk("wd_valid_down", 64'(mif.mem_req_valid), 64'd0);
      mif.mem_req_ready = 1'b1;
      tick(); tick();
      chk("wd_no_accept", 64'(req_addr_q.size() - r0), 64'd0);

      // read_enable dropped after accept: response discarded
      p0 = rdp_q.size();
      read_addr = 64'h9000;
      read_enable = 1'b1;
      tick(); tick();
      read_enable = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("da_one_req", 64'(req_addr_q.size() - r0), 64'd1);
      chk("da_no_pulse", 64'(rdp_q.size() - p0), 64'd0);
      chk("da_rd_words", 64'(rd_words), 64'd6);
      chk("da_idle", 64'(mif.mem_req_valid), 64'd0);
      chk("da_err_sticky", 64'(err), 64'd1);

      // Reset during RD_WAIT, response arrives afterwards and is ignored
      p0 = rdp_q.size();
      read_addr = 64'h7000;
      read_enable = 1'b1;
      tick(); tick();
      reset = 1'b1;
      read_enable = 1'b0;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("rw_no_pulse", 64'(rdp_q.size() - p0), 64'd0);
      chk("rw_rd_words", 64'(rd_words), 64'd0);
      chk("rw_wr_words", 64'(wr_words), 64'd0);
      chk("rw_err", 64'(err), 64'd0);
      chk("rw_read_data", 64'(read_data), 64'd0);
      chk("rw_read_ready", read_ready, 64'd0);
      chk("rw_idle", 64'(mif.mem_req_valid), 64'd0);

      // Strobe shape across the whole run
      chk("pulse_shape", 64'(pulse_bad), 64'd0);
      chk("pulse_latency", 64'(lat_bad), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
